proj_qsys_cpu_oci_trace_capture: RTL

PROJ_QSYS_CPU_OCI_TRACE_CAPTURE -- requirements
Module: proj_qsys_cpu_oci_trace_capture

---
 rtl/proj_qsys_cpu_oci_trace_pkg.sv | 40 ++++
 rtl/proj_qsys_cpu_oci_trace_fifo.sv | 95 +++++++++
 rtl/proj_qsys_cpu_oci_trace_capture.sv | 88 ++++++++
 3 files changed

// File: rtl/proj_qsys_cpu_oci_trace_pkg.sv
// Shared types and defaults for the OCI trace capture block.
package proj_qsys_cpu_oci_trace_pkg;

  localparam int unsigned DataWDefault = 30;
  localparam int unsigned CntWDefault  = 4;
  localparam int unsigned DepthDefault = 16;

  // Capture-control states: live capture, frozen on request, ended by the test.
  typedef enum logic [1:0] {
    StCapture = 2'd0,
    StFrozen  = 2'd1,
    StEnded   = 2'd2
  } trace_state_e;

  // End-of-test outranks a freeze request raised in the same cycle.
  // The unused encoding falls back to StCapture.
  function automatic trace_state_e trace_next_state(trace_state_e st, logic ending,
                                                    logic has_ended);
    trace_state_e nxt;
    nxt = st;
    unique case (st)
      StCapture: begin
        if (has_ended) begin
          nxt = StEnded;
        end else if (ending) begin
          nxt = StFrozen;
        end
      end
      StFrozen: begin
        if (has_ended) begin
          nxt = StEnded;
        end
      end
      StEnded: nxt = StEnded;
      default: nxt = StCapture;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/proj_qsys_cpu_oci_trace_fifo.sv
// Circular capture buffer with registered pop output and overwrite/drop-on-full policy.
module proj_qsys_cpu_oci_trace_fifo
  import proj_qsys_cpu_oci_trace_pkg::*;
#(
  parameter int unsigned  DATA_W    = DataWDefault,
  parameter int unsigned  DEPTH     = DepthDefault,
  parameter bit           OVERWRITE = 1'b1,
  localparam int unsigned AddrW     = $clog2(DEPTH),
  localparam int unsigned LvlW      = AddrW + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_req_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic [LvlW-1:0]   level_o,
  output logic              ovf_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AddrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]   level_q, level_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;

  logic empty, full;
  logic rd_acc, wr_acc, drop_oldest;

  assign empty = (level_q == '0);
  assign full  = (level_q == LvlW'(DEPTH));

  // A read frees a slot in the same cycle, so a full buffer with a read pending
  // takes the write as a plain pop+push and reports no overflow.
  assign rd_acc      = rd_req_i && !empty;
  assign wr_acc      = wr_en_i && (!full || rd_acc || OVERWRITE);
  assign drop_oldest = wr_en_i && full && !rd_acc && OVERWRITE;
  assign ovf_o       = wr_en_i && full && !rd_acc;

  // Pointer, level and read-port next state.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_acc;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + AddrW'(1);
    end
    if (rd_acc || drop_oldest) begin
      rd_ptr_d = rd_ptr_q + AddrW'(1);
    end
    if (rd_acc) begin
      rd_data_d = mem_q[rd_ptr_q];
    end

    if (wr_acc && !rd_acc && !full) begin
      level_d = level_q + LvlW'(1);
    end else if (rd_acc && !wr_acc) begin
      level_d = level_q - LvlW'(1);
    end
  end

  // Control state, synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Storage is left unreset; a pop reads the old word even when the same slot is rewritten.
  always_ff @(posedge clk_i) begin
    if (rst_ni && wr_acc) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign level_o    = level_q;

endmodule

// File: rtl/proj_qsys_cpu_oci_trace_capture.sv
// OCI trace capture: count-change detection, freeze/end control and a capture buffer.
module proj_qsys_cpu_oci_trace_capture
  import proj_qsys_cpu_oci_trace_pkg::*;
#(
  parameter int unsigned  DATA_W    = DataWDefault,
  parameter int unsigned  CNT_W     = CntWDefault,
  parameter int unsigned  DEPTH     = DepthDefault,
  parameter bit           OVERWRITE = 1'b1,
  localparam int unsigned ADDR_W    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] dct_buffer,
  input  logic [CNT_W-1:0]  dct_count,
  input  logic              test_ending,
  input  logic              test_has_ended,
  input  logic              rd_req,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              frozen,
  output logic              ended
);

  logic [CNT_W-1:0] prev_count_q;
  trace_state_e     state_q, state_d;
  logic             frozen_q, ended_q;
  logic             overflow_q;
  logic             capture;
  logic             ovf_evt;

  // Capture is decided on the current state, so a word arriving with test_ending is kept.
  assign capture = (state_q == StCapture) && (dct_count != prev_count_q);
  assign state_d = trace_next_state(state_q, test_ending, test_has_ended);

  // Track the last seen count to detect a new word.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev_count_q <= '0;
    end else begin
      prev_count_q <= dct_count;
    end
  end

  // Capture-control FSM with registered frozen/ended flags.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= StCapture;
      frozen_q <= 1'b0;
      ended_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      frozen_q <= (state_d != StCapture);
      ended_q  <= (state_d == StEnded);
    end
  end

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overflow_q <= 1'b0;
    end else if (ovf_evt) begin
      overflow_q <= 1'b1;
    end
  end

  proj_qsys_cpu_oci_trace_fifo #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .OVERWRITE (OVERWRITE)
  ) u_fifo (
    .clk_i      (clk),
    .rst_ni     (reset_n),
    .wr_en_i    (capture),
    .wr_data_i  (dct_buffer),
    .rd_req_i   (rd_req),
    .rd_data_o  (rd_data),
    .rd_valid_o (rd_valid),
    .level_o    (level),
    .ovf_o      (ovf_evt)
  );

  assign overflow = overflow_q;
  assign frozen   = frozen_q;
  assign ended    = ended_q;

endmodule
